// File: rtl/polarity_debounce_bank_pkg.sv
// Shared constants and helpers for the polarity debounce bank.
//   DEF_*       default parameter values for the bank
//   POL_INVERT  inv_mask bit value that inverts a channel
//   cnt_width() debounce counter width, never below one bit
package polarity_debounce_bank_pkg;

    localparam int unsigned DEF_WIDTH           = 8;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

    localparam logic POL_INVERT = 1'b1;
    localparam logic POL_PASS   = 1'b0;

    // Width needed to count 0..cycles-1; a single-cycle debounce still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : polarity_debounce_bank_pkg

// File: rtl/polarity_debounce_bank_debounce_channel.sv
// One debounce channel: synchroniser chain, persistence counter and accepted level.
//   clk, rst  clock and synchronous active-high reset
//   en        1 = counter and accepted level may advance; 0 = both hold
//   d         raw asynchronous input
//   q         accepted (debounced) level
module polarity_debounce_bank_debounce_channel
    import polarity_debounce_bank_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   acc_q;
    logic                   acc_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift and debounce counter; counter stops at CNT_LAST so it never wraps.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        if (en) begin
            if (s != acc_q) begin
                if (cnt_q == CNT_LAST) begin
                    acc_d = s;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                // Level matches again before acceptance: the glitch is discarded.
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

    assign q = acc_q;

endmodule : polarity_debounce_bank_debounce_channel

// File: rtl/polarity_debounce_bank.sv
// Bank of independent debounced inputs with per-channel programmable polarity.
//   clk, rst  clock and synchronous active-high reset
//   in        raw asynchronous inputs, one per channel
//   inv_mask  per-channel polarity (1 = invert), applied without debounce
//   en        debounce enable; 0 freezes counters and accepted levels
//   out       registered conditioned outputs (accepted level ^ inv_mask)
//   rise/fall single-cycle pulses on any out transition
//   changed   OR of all rise/fall pulses, aligned with them
module polarity_debounce_bank
    import polarity_debounce_bank_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] inv_mask,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             changed_q;
    logic             changed_d;

    // One debounce channel per input line.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chan
        polarity_debounce_bank_debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .en (en),
            .d  (in[i]),
            .q  (acc[i])
        );
    end

    // Polarity and edge detection; edges compare against the registered out,
    // so a mask flip that cancels an acceptance produces no pulse.
    always_comb begin
        out_d     = acc ^ inv_mask;
        rise_d    = out_d & ~out_q;
        fall_d    = ~out_d & out_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign out     = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule : polarity_debounce_bank

// File: tb/tb_polarity_debounce_bank.sv
// Directed self-checking bench for polarity_debounce_bank (WIDTH=4, SYNC=2, DEBOUNCE=4).
module tb_polarity_debounce_bank;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] inv_mask;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    int n_checks;
    int n_errors;

    polarity_debounce_bank #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .inv_mask(inv_mask),
        .en      (en),
        .out     (out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n edges; inputs are then driven / outputs sampled 1ns after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        in       = 4'h0;
        inv_mask = 4'hF;
        en       = 1'b1;

        // 1. reset then first edge loads inv_mask with rise pulses
        step(3);
        check("rst_out", 32'(out), 32'h0);
        check("rst_rise", 32'(rise), 32'h0);
        check("rst_changed", 32'(changed), 32'h0);
        rst = 1'b0;
        step(1);
        check("first_out", 32'(out), 32'hF);
        check("first_rise", 32'(rise), 32'hF);
        check("first_fall", 32'(fall), 32'h0);
        check("first_changed", 32'(changed), 32'h1);
        step(1);
        check("first_rise_end", 32'(rise), 32'h0);
        check("first_changed_end", 32'(changed), 32'h0);

        // 2. in[0] rises; inverted out[0] falls exactly 7 edges later
        in = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k < 7) begin
                check("lat_out_hold", 32'(out), 32'hF);
                check("lat_fall_hold", 32'(fall), 32'h0);
            end else begin
                check("lat_out_new", 32'(out), 32'hE);
                check("lat_fall", 32'(fall), 32'h1);
                check("lat_changed", 32'(changed), 32'h1);
            end
        end
        step(1);
        check("lat_fall_end", 32'(fall), 32'h0);
        check("lat_out_keep", 32'(out), 32'hE);

        // 3. 1-cycle and 3-cycle glitches on in[1] are discarded
        in = 4'h3;
        step(1);
        in = 4'h1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("glitch1_out", 32'(out), 32'hE);
            check("glitch1_edges", 32'(rise | fall), 32'h0);
        end
        in = 4'h3;
        step(3);
        in = 4'h1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("glitch3_out", 32'(out), 32'hE);
            check("glitch3_edges", 32'(rise | fall), 32'h0);
        end

        // 4. mask flip F->0 is reflected on the next edge without debounce
        inv_mask = 4'h0;
        step(1);
        check("mask_out", 32'(out), 32'h1);
        check("mask_rise", 32'(rise), 32'h1);
        check("mask_fall", 32'(fall), 32'hE);
        check("mask_changed", 32'(changed), 32'h1);
        step(1);
        check("mask_pulse_end", 32'(rise | fall), 32'h0);

        // 5. en=0 freezes acceptance; after en=1 out[2] updates 5 edges later
        en = 1'b0;
        in = 4'h5;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("frozen_out", 32'(out), 32'h1);
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            if (k < 5) begin
                check("en_out_hold", 32'(out), 32'h1);
            end else begin
                check("en_out_new", 32'(out), 32'h5);
                check("en_rise", 32'(rise), 32'h4);
            end
        end

        // 6. reset during a pending change on in[3]; full latency restarts at release
        in = 4'hD;
        step(2);
        rst = 1'b1;
        step(1);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_fall", 32'(fall), 32'h0);
        check("midrst_changed", 32'(changed), 32'h0);
        step(1);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k < 7) begin
                check("rel_out_hold", 32'(out), 32'h0);
            end else begin
                check("rel_out_new", 32'(out), 32'hD);
                check("rel_rise", 32'(rise), 32'hD);
            end
        end

        // 7. acceptance on in[1] coinciding with a mask flip leaves out unchanged
        in = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check("coinc_out", 32'(out), 32'hD);
            check("coinc_rise", 32'(rise), 32'h0);
            if (k == 6) begin
                inv_mask = 4'h2;
            end
        end
        check("coinc_changed", 32'(changed), 32'h0);
        step(1);
        check("coinc_out_after", 32'(out), 32'hD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_polarity_debounce_bank
